segment_search_engine: RTL and testbench

SEGMENT_SEARCH_ENGINE -- requirements
Module: segment_search_engine

---
 rtl/segment_search_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_segment_search_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_search_engine.sv
// -----------------------------------------------------------------------------
// segment_search_engine
//
// Splits a search key into FRAGMENTS fragments and, one fragment at a time,
// reads a rule segment from SDRAM at address {fragment index, key fragment}.
// The rule returned for fragment 0 becomes the candidate; the search hits
// only if every returned segment is valid and carries the candidate's rule id.
// One read is outstanding at a time. The result is reported with a one-cycle
// o_result_valid pulse; the result fields hold until the next result.
//
// Segment layout, MSB to LSB: {status[1:0], id, maskid, key, priority}
//   status[1] = segment valid, status[0] and the key field are not used.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   i_search_valid         search request
//   o_search_ready         engine idle, a request is accepted this cycle
//   i_search_key           key to search (KWID bits)
//   o_sdram_read           read request, held while i_sdram_waitrequest
//   o_sdram_address        segment address (ADDR_WID bits)
//   i_sdram_waitrequest    SDRAM stall
//   i_sdram_readdatavalid  read return strobe
//   i_sdram_readdata       returned segment (SEGWID bits)
//   o_result_valid         one-cycle result strobe
//   o_result_hit           all fragments matched the candidate rule
//   o_result_id            candidate rule id
//   o_result_maskid        candidate mask id
//   o_result_priority      candidate priority
//
// Build option
//   SEGMENT_SEARCH_EARLY_EXIT_EN  when defined, the search finishes as soon as
//                                 a returned fragment rules out a hit, instead
//                                 of reading all FRAGMENTS fragments.
// -----------------------------------------------------------------------------
module segment_search_engine #(
    parameter  int DATA_BITS = 10,
    parameter  int FRAGMENTS = 5,
    parameter  int FRAG_BITS = 3,
    parameter  int IDWID     = 2,
    parameter  int MASKWID   = 5,
    localparam int PRIOWID   = IDWID,
    localparam int FRAG_WID  = DATA_BITS / FRAGMENTS,
    localparam int ADDR_WID  = FRAG_BITS + FRAG_WID,
    localparam int KWID      = DATA_BITS,
    localparam int SEGWID    = 2 + IDWID + MASKWID + KWID + PRIOWID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_search_valid,
    output logic                o_search_ready,
    input  logic [KWID-1:0]     i_search_key,
    output logic                o_sdram_read,
    output logic [ADDR_WID-1:0] o_sdram_address,
    input  logic                i_sdram_waitrequest,
    input  logic                i_sdram_readdatavalid,
    input  logic [SEGWID-1:0]   i_sdram_readdata,
    output logic                o_result_valid,
    output logic                o_result_hit,
    output logic [IDWID-1:0]    o_result_id,
    output logic [MASKWID-1:0]  o_result_maskid,
    output logic [PRIOWID-1:0]  o_result_priority
);

    localparam logic [FRAG_BITS-1:0] LAST_FRAG = FRAG_BITS'(FRAGMENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    logic [KWID-1:0]      key_reg;
    logic [FRAG_BITS-1:0] frag_idx;
    logic                 hit;
    logic [IDWID-1:0]     cand_id;
    logic [MASKWID-1:0]   cand_maskid;
    logic [PRIOWID-1:0]   cand_prio;

    // Decoded fields of the returned segment
    logic [1:0]           seg_status;
    logic [IDWID-1:0]     seg_id;
    logic [MASKWID-1:0]   seg_maskid;
    logic [KWID-1:0]      seg_key;
    logic [PRIOWID-1:0]   seg_prio;
    logic                 unused_seg_bits;

    // Candidate and hit as they stand once the current return is absorbed
    logic                 frag_is_first;
    logic                 frag_is_last;
    logic [IDWID-1:0]     cand_id_n;
    logic [MASKWID-1:0]   cand_maskid_n;
    logic [PRIOWID-1:0]   cand_prio_n;
    logic                 hit_n;
    logic                 early_exit;

    // Next fragment index and the key fragment it addresses
    logic [FRAG_BITS-1:0] next_frag;
    logic [FRAG_WID-1:0]  next_frag_key;

    always_comb begin
        seg_status      = i_sdram_readdata[SEGWID-1 -: 2];
        seg_id          = i_sdram_readdata[SEGWID-3 -: IDWID];
        seg_maskid      = i_sdram_readdata[PRIOWID+KWID +: MASKWID];
        seg_key         = i_sdram_readdata[PRIOWID +: KWID];
        seg_prio        = i_sdram_readdata[PRIOWID-1:0];
        unused_seg_bits = ^{seg_status[0], seg_key};
    end

    always_comb begin
        frag_is_first = (frag_idx == '0);
        frag_is_last  = (frag_idx == LAST_FRAG);

        // Fragment 0 defines the candidate, so its fields are used directly
        // when the result is taken from the same return that loads them.
        cand_id_n     = frag_is_first ? seg_id     : cand_id;
        cand_maskid_n = frag_is_first ? seg_maskid : cand_maskid;
        cand_prio_n   = frag_is_first ? seg_prio   : cand_prio;

        hit_n = (frag_is_first ? 1'b1 : hit)
              & seg_status[1]
              & (frag_is_first | (seg_id == cand_id));

`ifdef SEGMENT_SEARCH_EARLY_EXIT_EN
        early_exit = ~hit_n;
`else
        early_exit = 1'b0;
`endif
    end

    always_comb begin
        next_frag     = frag_idx + FRAG_BITS'(1);
        next_frag_key = '0;
        for (int unsigned i = 0; i < FRAGMENTS; i++) begin
            if (next_frag == FRAG_BITS'(i)) begin
                next_frag_key = key_reg[i*FRAG_WID +: FRAG_WID];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            key_reg           <= '0;
            frag_idx          <= '0;
            hit               <= 1'b0;
            cand_id           <= '0;
            cand_maskid       <= '0;
            cand_prio         <= '0;
            o_search_ready    <= 1'b1;
            o_sdram_read      <= 1'b0;
            o_sdram_address   <= '0;
            o_result_valid    <= 1'b0;
            o_result_hit      <= 1'b0;
            o_result_id       <= '0;
            o_result_maskid   <= '0;
            o_result_priority <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_search_valid) begin
                        key_reg         <= i_search_key;
                        frag_idx        <= '0;
                        hit             <= 1'b1;
                        o_sdram_read    <= 1'b1;
                        o_sdram_address <= {{FRAG_BITS{1'b0}}, i_search_key[FRAG_WID-1:0]};
                        o_search_ready  <= 1'b0;
                        state           <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Address and read stay put until the SDRAM takes them
                    if (!i_sdram_waitrequest) begin
                        o_sdram_read <= 1'b0;
                        state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_sdram_readdatavalid) begin
                        hit         <= hit_n;
                        cand_id     <= cand_id_n;
                        cand_maskid <= cand_maskid_n;
                        cand_prio   <= cand_prio_n;
                        if (frag_is_last || early_exit) begin
                            o_result_valid    <= 1'b1;
                            o_result_hit      <= hit_n;
                            o_result_id       <= cand_id_n;
                            o_result_maskid   <= cand_maskid_n;
                            o_result_priority <= cand_prio_n;
                            state             <= S_DONE;
                        end else begin
                            frag_idx        <= next_frag;
                            o_sdram_read    <= 1'b1;
                            o_sdram_address <= {next_frag, next_frag_key};
                            state           <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    o_result_valid <= 1'b0;
                    o_search_ready <= 1'b1;
                    frag_idx       <= '0;
                    state          <= S_IDLE;
                end

                default: begin
                    o_search_ready <= 1'b1;
                    o_sdram_read   <= 1'b0;
                    o_result_valid <= 1'b0;
                    frag_idx       <= '0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_search_engine.sv
// -----------------------------------------------------------------------------
// tb_segment_search_engine
//
// Directed bench for segment_search_engine at default parameters. An inline
// SDRAM responder returns each accepted read one cycle later with a segment
// taken from per-fragment tables; optional wait-request stalls per fragment.
// Expected addresses, latencies and result fields are hand-computed.
// -----------------------------------------------------------------------------
module tb_segment_search_engine;

    localparam int DATA_BITS = 10;
    localparam int FRAGMENTS = 5;
    localparam int FRAG_BITS = 3;
    localparam int IDWID     = 2;
    localparam int MASKWID   = 5;
    localparam int KWID      = 10;
    localparam int SEGWID    = 21;
    localparam int ADDR_WID  = 5;

    logic                clk;
    logic                reset;
    logic                i_search_valid;
    logic                o_search_ready;
    logic [KWID-1:0]     i_search_key;
    logic                o_sdram_read;
    logic [ADDR_WID-1:0] o_sdram_address;
    logic                i_sdram_waitrequest;
    logic                i_sdram_readdatavalid;
    logic [SEGWID-1:0]   i_sdram_readdata;
    logic                o_result_valid;
    logic                o_result_hit;
    logic [IDWID-1:0]    o_result_id;
    logic [MASKWID-1:0]  o_result_maskid;
    logic [IDWID-1:0]    o_result_priority;

    segment_search_engine #(
        .DATA_BITS (DATA_BITS),
        .FRAGMENTS (FRAGMENTS),
        .FRAG_BITS (FRAG_BITS),
        .IDWID     (IDWID),
        .MASKWID   (MASKWID)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .i_search_valid        (i_search_valid),
        .o_search_ready        (o_search_ready),
        .i_search_key          (i_search_key),
        .o_sdram_read          (o_sdram_read),
        .o_sdram_address       (o_sdram_address),
        .i_sdram_waitrequest   (i_sdram_waitrequest),
        .i_sdram_readdatavalid (i_sdram_readdatavalid),
        .i_sdram_readdata      (i_sdram_readdata),
        .o_result_valid        (o_result_valid),
        .o_result_hit          (o_result_hit),
        .o_result_id           (o_result_id),
        .o_result_maskid       (o_result_maskid),
        .o_result_priority     (o_result_priority)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-fragment response tables
    logic [1:0]         st_tab   [FRAGMENTS];
    logic [1:0]         id_tab   [FRAGMENTS];
    logic [MASKWID-1:0] mask_tab [FRAGMENTS];
    logic [1:0]         prio_tab [FRAGMENTS];
    int                 stall_tab[FRAGMENTS];

    // Observations from the last search
    int                 r_reads;
    logic [4:0]         r_addr[8];
    int                 r_valid_edge;
    int                 r_valid_cnt;
    bit                 r_ready_high;
    logic               r_hit;
    logic [1:0]         r_id;
    logic [MASKWID-1:0] r_mask;
    logic [1:0]         r_prio;
    logic               s1_ready, s1_read, s1_hit;
    logic [1:0]         s1_id;
    logic               s2_ready, s2_read;
    logic [4:0]         s2_addr;

    // Hand-computed addresses for key 10'b11_10_01_00_11: {f, key[2f+1:2f]}
    logic [4:0] exp_addr[5] = '{5'b00011, 5'b00100, 5'b01001, 5'b01110, 5'b10011};

    localparam logic [KWID-1:0] KEY_A = 10'b11_10_01_00_11;
    localparam logic [KWID-1:0] KEY_B = 10'b01_10_11_00_01;

    // Fragment 0 carries the candidate fields; later fragments carry
    // different mask/priority values that must not reach the result.
    task automatic set_tables(input int bad_id_frag, input int bad_st_frag, input int stall_frag);
        for (int f = 0; f < FRAGMENTS; f++) begin
            st_tab[f]    = (f == 3) ? 2'b11 : 2'b10;
            id_tab[f]    = 2'b01;
            mask_tab[f]  = (f == 0) ? 5'b10101 : MASKWID'(f);
            prio_tab[f]  = (f == 0) ? 2'b11 : 2'(f);
            stall_tab[f] = 0;
        end
        if (bad_id_frag >= 0) id_tab[bad_id_frag] = 2'b10;
        if (bad_st_frag >= 0) st_tab[bad_st_frag] = 2'b01;
        if (stall_frag >= 0) stall_tab[stall_frag] = 4;
    endtask

    function automatic logic [SEGWID-1:0] seg_of(input int f);
        logic [KWID-1:0] k;
        k = KWID'(f * 77 + 5);
        return {st_tab[f], id_tab[f], mask_tab[f], k, prio_tab[f]};
    endfunction

    // Runs one search. Edge 1 is the acceptance edge; observations are
    // taken on the falling edge after each rising edge. abort_reads > 0
    // returns just after that many reads were accepted (read outstanding).
    task automatic do_search(input logic [KWID-1:0] key, input bit hold, input int abort_reads);
        int         edge_n;
        bit         pend;
        bit         stalling;
        int         stall_left;
        logic [4:0] held_addr;
        r_reads      = 0;
        r_valid_edge = -1;
        r_valid_cnt  = 0;
        r_ready_high = 0;
        pend         = 0;
        stalling     = 0;
        stall_left   = 0;
        held_addr    = '0;
        @(negedge clk);
        check_eq("ready_before_search", 32'(o_search_ready), 32'd1);
        i_search_valid = 1'b1;
        i_search_key   = key;
        @(posedge clk);
        edge_n = 1;
        while (edge_n <= 60) begin
            @(negedge clk);
            if (!hold) i_search_valid = 1'b0;
            if (pend) begin
                i_sdram_readdatavalid = 1'b1;
                i_sdram_readdata      = seg_of(r_reads - 1);
                pend                  = 0;
            end else begin
                i_sdram_readdatavalid = 1'b0;
                i_sdram_readdata      = '0;
            end
            if (o_result_valid) begin
                r_valid_cnt++;
                if (r_valid_edge < 0) begin
                    r_valid_edge = edge_n;
                    r_hit  = o_result_hit;
                    r_id   = o_result_id;
                    r_mask = o_result_maskid;
                    r_prio = o_result_priority;
                end
            end
            if ((r_valid_edge < 0 || edge_n == r_valid_edge) && o_search_ready) r_ready_high = 1;
            if (r_valid_edge >= 0 && edge_n == r_valid_edge + 1) begin
                s1_ready = o_search_ready;
                s1_read  = o_sdram_read;
                s1_hit   = o_result_hit;
                s1_id    = o_result_id;
            end
            if (r_valid_edge >= 0 && edge_n == r_valid_edge + 2) begin
                s2_ready = o_search_ready;
                s2_read  = o_sdram_read;
                s2_addr  = o_sdram_address;
                break;
            end
            if (o_sdram_read && r_reads < FRAGMENTS) begin
                if (!stalling) begin
                    stalling   = 1;
                    stall_left = stall_tab[r_reads];
                    held_addr  = o_sdram_address;
                end else begin
                    check_eq("addr_stable_in_stall", 32'(o_sdram_address), 32'(held_addr));
                end
                if (stall_left > 0) begin
                    i_sdram_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    i_sdram_waitrequest = 1'b0;
                    r_addr[r_reads] = o_sdram_address;
                    r_reads++;
                    pend     = 1;
                    stalling = 0;
                end
            end else begin
                if (stalling) check_eq("read_held_in_stall", 32'(o_sdram_read), 32'd1);
                stalling = 0;
                i_sdram_waitrequest = 1'b0;
            end
            if (abort_reads > 0 && r_reads == abort_reads) begin
                @(posedge clk);
                #2;
                i_search_valid = 1'b0;
                return;
            end
            @(posedge clk);
            edge_n++;
        end
        if (r_valid_edge < 0) check_eq("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},  32'(o_search_ready),    32'd1);
        check_eq({tag, "_read"},   32'(o_sdram_read),      32'd0);
        check_eq({tag, "_addr"},   32'(o_sdram_address),   32'd0);
        check_eq({tag, "_valid"},  32'(o_result_valid),    32'd0);
        check_eq({tag, "_hit"},    32'(o_result_hit),      32'd0);
        check_eq({tag, "_id"},     32'(o_result_id),       32'd0);
        check_eq({tag, "_maskid"}, 32'(o_result_maskid),   32'd0);
        check_eq({tag, "_prio"},   32'(o_result_priority), 32'd0);
    endtask

`ifdef SEGMENT_SEARCH_EARLY_EXIT_EN
    localparam int EXP_READS_BAD2 = 3;
    localparam int EXP_EDGE_BAD2  = 7;
    localparam int EXP_READS_BAD0 = 1;
    localparam int EXP_EDGE_BAD0  = 3;
`else
    localparam int EXP_READS_BAD2 = 5;
    localparam int EXP_EDGE_BAD2  = 11;
    localparam int EXP_READS_BAD0 = 5;
    localparam int EXP_EDGE_BAD0  = 11;
`endif

    initial begin
        reset                 = 1'b1;
        i_search_valid        = 1'b0;
        i_search_key          = '0;
        i_sdram_waitrequest   = 1'b0;
        i_sdram_readdatavalid = 1'b0;
        i_sdram_readdata      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // All fragments match: hit, full latency
        set_tables(-1, -1, -1);
        do_search(KEY_A, 1'b0, 0);
        check_eq("basic_reads", 32'(r_reads), 32'd5);
        for (int f = 0; f < 5; f++) check_eq("basic_addr", 32'(r_addr[f]), 32'(exp_addr[f]));
        check_eq("basic_latency",   32'(r_valid_edge), 32'd11);
        check_eq("basic_pulses",    32'(r_valid_cnt),  32'd1);
        check_eq("basic_hit",       32'(r_hit),        32'd1);
        check_eq("basic_id",        32'(r_id),         32'b01);
        check_eq("basic_maskid",    32'(r_mask),       32'b10101);
        check_eq("basic_prio",      32'(r_prio),       32'b11);
        check_eq("basic_busy",      32'(r_ready_high), 32'd0);
        check_eq("basic_hold_hit",  32'(s1_hit),       32'd1);
        check_eq("basic_hold_id",   32'(s1_id),        32'b01);
        check_eq("basic_idle",      32'(s1_ready),     32'd1);
        check_eq("basic_no_reread", 32'(s2_read),      32'd0);

        // Fragment 2 carries a different rule id
        set_tables(2, -1, -1);
        do_search(KEY_A, 1'b0, 0);
        check_eq("idmiss_reads",   32'(r_reads),      32'(EXP_READS_BAD2));
        check_eq("idmiss_latency", 32'(r_valid_edge), 32'(EXP_EDGE_BAD2));
        check_eq("idmiss_hit",     32'(r_hit),        32'd0);
        check_eq("idmiss_id",      32'(r_id),         32'b01);
        check_eq("idmiss_pulses",  32'(r_valid_cnt),  32'd1);

        // Fragment 0 returns an invalid segment
        set_tables(-1, 0, -1);
        do_search(KEY_A, 1'b0, 0);
        check_eq("inval0_reads",   32'(r_reads),      32'(EXP_READS_BAD0));
        check_eq("inval0_latency", 32'(r_valid_edge), 32'(EXP_EDGE_BAD0));
        check_eq("inval0_hit",     32'(r_hit),        32'd0);
        check_eq("inval0_maskid",  32'(r_mask),       32'b10101);

        // Four wait-request cycles on fragment 1
        set_tables(-1, -1, 1);
        do_search(KEY_A, 1'b0, 0);
        check_eq("stall_reads",   32'(r_reads),      32'd5);
        check_eq("stall_addr1",   32'(r_addr[1]),    32'b00100);
        check_eq("stall_latency", 32'(r_valid_edge), 32'd15);
        check_eq("stall_hit",     32'(r_hit),        32'd1);
        check_eq("stall_id",      32'(r_id),         32'b01);
        check_eq("stall_prio",    32'(r_prio),       32'b11);

        // Reset while waiting on fragment 3, then a stray return
        set_tables(-1, -1, -1);
        do_search(KEY_A, 1'b0, 4);
        check_eq("abort_reads", 32'(r_reads), 32'd4);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        #1;
        reset = 1'b0;
        @(negedge clk);
        i_sdram_readdatavalid = 1'b1;
        i_sdram_readdata      = seg_of(3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_sdram_readdatavalid = 1'b0;
            i_sdram_readdata      = '0;
            check_eq("post_reset_valid", 32'(o_result_valid), 32'd0);
            check_eq("post_reset_ready", 32'(o_search_ready), 32'd1);
            check_eq("post_reset_read",  32'(o_sdram_read),   32'd0);
        end
        check_reset_outputs("post_reset");

        // Request held high: next search starts only after DONE
        do_search(KEY_B, 1'b1, 0);
        check_eq("hold_latency",    32'(r_valid_edge), 32'd11);
        check_eq("hold_hit",        32'(r_hit),        32'd1);
        check_eq("hold_busy",       32'(r_ready_high), 32'd0);
        check_eq("hold_idle_ready", 32'(s1_ready),     32'd1);
        check_eq("hold_idle_read",  32'(s1_read),      32'd0);
        check_eq("hold_next_ready", 32'(s2_ready),     32'd0);
        check_eq("hold_next_read",  32'(s2_read),      32'd1);
        check_eq("hold_next_addr",  32'(s2_addr),      32'b00001);
        i_search_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
